eth_fifo_frame_reader: RTL
==========================

# eth_fifo_frame_reader

Drains committed Ethernet payload frames from the 8-bit, 2048-entry prefetch (show-ahead) payload FIFO and feeds them byte-by-byte to the UDP transmitter. The upstream writer pushes payload bytes into the FIFO, then commits each frame's length to this block. The block queues those lengths, starts one UDP transmission per frame, and pops exactly that many FIFO bytes on the transmitter's byte requests.

## Interface
- LEN_W, 11, frame length width; maximum frame is 2047 bytes, matching the FIFO depth
- LQ_DEPTH_W, 2, log2 of the length-queue depth (4 entries)
- IDLE_GAP, 12, idle cycles between tx_done and the next frame start; 0 means no gap

- clk  in  1  system clock; payload FIFO and UDP TX share this clock
- rst_n  in  1  reset, synchronous, active-low
- len_wr  in  1  commit pulse: the frame of len_data bytes is fully written to the FIFO
- len_data  in  LEN_W  committed frame length
- len_full  out  1  length queue full
- fifo_rd_en  out  1  pop the FIFO head byte
- fifo_rd_vld  in  1  FIFO head byte valid on fifo_rd_data
- fifo_rd_data  in  8  FIFO head byte (show-ahead)
- tx_start_en  out  1  one-cycle frame start pulse to UDP TX
- tx_byte_num  out  LEN_W  payload length of the current frame; stable from tx_start_en until tx_done
- tx_req  in  1  UDP TX requests the next payload byte
- tx_data  out  8  payload byte, registered
- tx_done  in  1  UDP TX finished the frame
- busy  out  1  state is not IDLE
- err  out  2  sticky flags: [0] underrun, [1] length-queue overflow; cleared only by reset

## Operation
- Length queue: circular, 2^LQ_DEPTH_W entries.
  - Push on len_wr when not full.
  - Push while full: entry dropped, err[1] set.
  - Simultaneous push and pop is legal when full.
- State machine: IDLE, START, SEND, WAIT_DONE, FLUSH, GAP.
- IDLE: if the queue is non-empty, pop the head.
  - Length 0: discard the entry and stay in IDLE.
  - Otherwise: latch tx_byte_num, load rem = length, go to START.
- START: tx_start_en = 1 for one cycle, then SEND.
- SEND: each tx_req cycle with rem > 0:
  - fifo_rd_en = tx_req & fifo_rd_vld (combinational).
  - tx_data <= fifo_rd_data, or 0x00 with err[0] set if fifo_rd_vld = 0.
  - rem decrements in both cases.
  - When rem reaches 0, go to WAIT_DONE.
  - tx_req with rem = 0 is ignored; tx_data holds its value.
- SEND, tx_done while rem > 0 (transmitter abort): go to FLUSH.
- FLUSH: fifo_rd_en = fifo_rd_vld, rem decrements per pop; at rem = 0 go to GAP. This keeps FIFO frame alignment.
- WAIT_DONE: on tx_done go to GAP.
- GAP: count IDLE_GAP cycles, then IDLE. With IDLE_GAP = 0, go straight to IDLE.
- rem is LEN_W wide and never wraps below 0.

## Timing
- Reset (rst_n low at a clk edge) forces:
  - state IDLE, queue empty, rem = 0
  - tx_start_en = 0, tx_byte_num = 0, tx_data = 0x00, fifo_rd_en = 0, busy = 0, err = 0
- Reset mid-frame aborts at once; already-popped FIFO bytes are not restored.
- Latencies:
  - queue non-empty in IDLE → tx_start_en 1 cycle later
  - tx_req at cycle n → tx_data valid at n+1
  - fifo_rd_en is asserted in cycle n itself
- Back-to-back tx_req every cycle is supported at 1 byte/clk.
- len_wr in the same cycle IDLE pops: the new entry is visible from the next cycle.

## Configuration
- ETH_TX_PAD_EN defined: frames shorter than 18 bytes are padded to the minimum 64-byte Ethernet frame.
  - tx_byte_num = max(len, 18).
  - Requests beyond len drive tx_data = 0x00 without popping the FIFO and do not set err[0].
- ETH_TX_PAD_EN undefined: tx_byte_num = len and no padding logic exists.

## Test plan
- Preload the FIFO with 0x00..0x3F, commit len 64, tx_req continuous → tx_start_en one pulse, tx_byte_num = 64, tx_data = 0x00..0x3F on the cycles after each req, FIFO empty, err = 0.
- Commit 5 lengths while the first frame is active → 5th push sets err[1] and len_full; the remaining 4 frames transmit in order, each start ≥ IDLE_GAP+1 cycles after tx_done.
- Commit len 10 with only 8 bytes in the FIFO → bytes 9–10 are 0x00 and err[0] = 1.
- Commit 100, pulse tx_done after 40 requests, second frame of 20 bytes 0xA0.. queued → FLUSH pops 60 bytes; second frame outputs 0xA0 first.
- With ETH_TX_PAD_EN, commit len 4 (0x11..0x14) → tx_byte_num = 18; data 0x11..0x14 then 14 × 0x00; exactly 4 FIFO pops.
- Assert rst_n low in SEND → the next cycle shows all outputs at their reset values; a new commit afterwards transmits normally.

Source files
------------

// File: rtl/eth_fifo_frame_reader_if.sv
// Bundle of the three handshakes around the frame reader: length commit,
// show-ahead payload FIFO read port and UDP TX byte port.
interface eth_fifo_frame_reader_if #(
   parameter int LEN_W = 11
);
   logic             len_wr;
   logic [LEN_W-1:0] len_data;
   logic             len_full;
   logic             fifo_rd_en;
   logic             fifo_rd_vld;
   logic [7:0]       fifo_rd_data;
   logic             tx_start_en;
   logic [LEN_W-1:0] tx_byte_num;
   logic             tx_req;
   logic [7:0]       tx_data;
   logic             tx_done;

   modport master (
      input  len_wr, len_data, fifo_rd_vld, fifo_rd_data, tx_req, tx_done,
      output len_full, fifo_rd_en, tx_start_en, tx_byte_num, tx_data
   );

   modport slave (
      output len_wr, len_data, fifo_rd_vld, fifo_rd_data, tx_req, tx_done,
      input  len_full, fifo_rd_en, tx_start_en, tx_byte_num, tx_data
   );
endinterface

// File: rtl/eth_fifo_frame_reader.sv
// Drains committed payload frames from a show-ahead byte FIFO into the UDP TX byte port.
// Optional ETH_TX_PAD_EN: frames shorter than 18 bytes are zero-padded to 18 payload bytes.
module eth_fifo_frame_reader #(
   parameter int LEN_W      = 11,
   parameter int LQ_DEPTH_W = 2,
   parameter int IDLE_GAP   = 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
   eth_fifo_frame_reader_if.master bus,
   output logic                    busy,
   output logic [1:0]              err
);
   localparam int LQ_DEPTH = 1 << LQ_DEPTH_W;
   localparam int GAP_W    = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
`ifdef ETH_TX_PAD_EN
   localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(18);
`endif

   typedef enum logic [2:0] {IDLE, START, SEND, WAIT_DONE, FLUSH, GAP} state_t;

   state_t                state_q, state_d;
   logic [LEN_W-1:0]      lq_mem_q [LQ_DEPTH];
   logic [LQ_DEPTH_W-1:0] lq_wr_q, lq_wr_d;
   logic [LQ_DEPTH_W-1:0] lq_rd_q, lq_rd_d;
   logic [LQ_DEPTH_W:0]   lq_cnt_q, lq_cnt_d;
   logic [LEN_W-1:0]      rem_q, rem_d;
   logic [LEN_W-1:0]      byte_num_q, byte_num_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  start_q, start_d;
   logic [1:0]            err_q, err_d;
   logic [GAP_W-1:0]      gap_q, gap_d;
`ifdef ETH_TX_PAD_EN
   logic [LEN_W-1:0]      pay_q, pay_d;
`endif

   logic                  lq_full, lq_empty, lq_push, lq_pop;
   logic [LEN_W-1:0]      lq_head;
   logic [LEN_W-1:0]      rem_dec;
   logic                  rd_en;
   logic                  owe_fifo;

   function automatic state_t after_done();
      if (IDLE_GAP == 0) return IDLE;
      return GAP;
   endfunction

   assign lq_full  = (lq_cnt_q == (LQ_DEPTH_W+1)'(LQ_DEPTH));
   assign lq_empty = (lq_cnt_q == '0);
   assign lq_head  = lq_mem_q[lq_rd_q];
   assign rem_dec  = (rem_q != '0) ? rem_q - LEN_W'(1) : '0;

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      byte_num_d = byte_num_q;
      tx_data_d  = tx_data_q;
      start_d    = 1'b0;
      err_d      = err_q;
      gap_d      = gap_q;
      lq_pop     = 1'b0;
      rd_en      = 1'b0;
`ifdef ETH_TX_PAD_EN
      pay_d      = pay_q;
      owe_fifo   = (pay_q != '0);
`else
      owe_fifo   = 1'b1;
`endif

      case (state_q)
         IDLE: begin
            if (!lq_empty) begin
               lq_pop = 1'b1;
               if (lq_head != '0) begin
`ifdef ETH_TX_PAD_EN
                  byte_num_d = (lq_head < MIN_LEN) ? MIN_LEN : lq_head;
                  pay_d      = lq_head;
`else
                  byte_num_d = lq_head;
`endif
                  rem_d   = byte_num_d;
                  start_d = 1'b1;
                  state_d = START;
               end
            end
         end
         START: state_d = SEND;
         SEND: begin
            if (bus.tx_req && rem_q != '0) begin
               rem_d = rem_dec;
               if (!owe_fifo) begin
                  tx_data_d = 8'h00;
               end else begin
                  rd_en = bus.fifo_rd_vld;
`ifdef ETH_TX_PAD_EN
                  pay_d = pay_q - LEN_W'(1);
`endif
                  if (bus.fifo_rd_vld) begin
                     tx_data_d = bus.fifo_rd_data;
                  end else begin
                     tx_data_d = 8'h00;
                     err_d[0]  = 1'b1;
                  end
               end
            end
            // An abort leaves the unsent FIFO bytes of this frame to be flushed.
            if (bus.tx_done) begin
`ifdef ETH_TX_PAD_EN
               rem_d = pay_d;
`endif
               gap_d   = '0;
               state_d = (rem_d == '0) ? after_done() : FLUSH;
            end else if (rem_d == '0) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (bus.tx_done) begin
               gap_d   = '0;
               state_d = after_done();
            end
         end
         FLUSH: begin
            if (rem_q == '0) begin
               gap_d   = '0;
               state_d = after_done();
            end else if (bus.fifo_rd_vld) begin
               rd_en = 1'b1;
               rem_d = rem_dec;
               if (rem_dec == '0) begin
                  gap_d   = '0;
                  state_d = after_done();
               end
            end
         end
         GAP: begin
            if (gap_q == GAP_W'(IDLE_GAP - 1)) state_d = IDLE;
            else                               gap_d   = gap_q + GAP_W'(1);
         end
         default: state_d = IDLE;
      endcase

      // A push into a full queue is still accepted when IDLE pops the same cycle.
      lq_push = bus.len_wr && (!lq_full || lq_pop);
      if (bus.len_wr && !lq_push) err_d[1] = 1'b1;
      lq_wr_d  = lq_wr_q + LQ_DEPTH_W'(lq_push);
      lq_rd_d  = lq_rd_q + LQ_DEPTH_W'(lq_pop);
      lq_cnt_d = lq_cnt_q + (LQ_DEPTH_W+1)'(lq_push) - (LQ_DEPTH_W+1)'(lq_pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         lq_wr_q    <= '0;
         lq_rd_q    <= '0;
         lq_cnt_q   <= '0;
         rem_q      <= '0;
         byte_num_q <= '0;
         tx_data_q  <= 8'h00;
         start_q    <= 1'b0;
         err_q      <= '0;
         gap_q      <= '0;
`ifdef ETH_TX_PAD_EN
         pay_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         lq_wr_q    <= lq_wr_d;
         lq_rd_q    <= lq_rd_d;
         lq_cnt_q   <= lq_cnt_d;
         rem_q      <= rem_d;
         byte_num_q <= byte_num_d;
         tx_data_q  <= tx_data_d;
         start_q    <= start_d;
         err_q      <= err_d;
         gap_q      <= gap_d;
`ifdef ETH_TX_PAD_EN
         pay_q      <= pay_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && lq_push) lq_mem_q[lq_wr_q] <= bus.len_data;
   end

   assign bus.len_full    = lq_full;
   assign bus.fifo_rd_en  = rd_en;
   assign bus.tx_start_en = start_q;
   assign bus.tx_byte_num = byte_num_q;
   assign bus.tx_data     = tx_data_q;
   assign busy            = (state_q != IDLE);
   assign err             = err_q;
endmodule
